nw_row_sched: RTL and testbench
===============================

NW_ROW_SCHED -- requirements
Module: nw_row_sched

Interface
REQ-001 SHALL have parameter LENGTH, default 10: characters per string; also the number of rows swept.
REQ-002 SHALL have parameter CWIDTH, default 2: bits per character.
REQ-003 SHALL have parameter SWIDTH, default 16: bits per signed score.
REQ-004 SHALL have parameters MATCH, INDEL, MISMATCH, signed, defaults 1, -1, -1: scoring weights.
REQ-005 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1: a job is offered on s1/s2.
REQ-008 SHALL have port in_ready  output  1: the block can accept a job.
REQ-009 SHALL have port s1  input  LENGTH*CWIDTH: first string; character i (1-based) is s1[CWIDTH*(LENGTH-i) +: CWIDTH].
REQ-010 SHALL have port s2  input  LENGTH*CWIDTH: second string; same packing as s1.
REQ-011 SHALL have port out_valid  output  1: score is valid.
REQ-012 SHALL have port out_ready  input  1: the consumer accepts score.
REQ-013 SHALL have port score  output  SWIDTH signed: Needleman-Wunsch global alignment score.
REQ-014 SHALL have port busy  output  1: high in RUN and DONE states.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; out_valid only in DONE; busy = !IDLE.
REQ-017 On the IDLE edge with in_valid&&in_ready: latch s1/s2, load row register R[j] = -j*|INDEL| boundary (j=1..LENGTH, INDEL scaled), set row counter i=1, enter RUN.
REQ-018 Each RUN cycle SHALL compute row i through one chain of LENGTH cells, combinationally left to right.
- top = R[j]
- left = new[j-1]; for j=1, left = i*INDEL
- top-left = R[j-1]; for j=1, top-left = (i-1)*INDEL
- chars s1[i], s2[j]
REQ-019 Cell function SHALL be: max(top+INDEL, left+INDEL, topleft+(c1==c2?MATCH:MISMATCH)); ties are irrelevant to the value.
REQ-020 The RUN edge SHALL write new[] into R and increment i; the edge with i==LENGTH SHALL enter DONE instead.
REQ-021 Latency: out_valid SHALL rise exactly LENGTH cycles after the accept edge.
REQ-022 score SHALL equal R[LENGTH] and SHALL be held stable while out_valid is high.
REQ-023 The DONE edge with out_ready SHALL return to IDLE; otherwise remain in DONE (backpressure, unbounded).
REQ-024 No job is accepted in the same cycle as the output handshake; the next accept is earliest one cycle later.
REQ-025 in_valid during RUN/DONE SHALL be ignored; s1/s2 changes after accept SHALL have no effect.
REQ-026 All arithmetic SHALL be signed SWIDTH two's complement and wrap on overflow; boundary constants are sign-extended to SWIDTH.
REQ-027 Row counter width SHALL be clog2(LENGTH+1); LENGTH=1 completes in one RUN cycle.

Reset
REQ-028 reset SHALL put the FSM in IDLE, clear i, R, score and out_valid to 0, and set in_ready=1 and busy=0 on the next edge.
REQ-029 reset mid-RUN or mid-DONE SHALL abort the job with no output; reset has priority over any handshake in the same cycle.

Structure
REQ-030 State encodings and default weight constants SHALL live in a shared include/package nw_pkg, reused by future nw blocks.
REQ-031 The per-cell max function SHALL be a sub-module nw_cell, instantiated LENGTH times in a generate loop; the FSM, row register, counter and handshake logic stay in nw_row_sched.

Verification (LENGTH=4, CWIDTH=2, defaults)
REQ-032 Match: s1=s2=8'h1B (ACGT) -> score=4; out_valid exactly 4 cycles after accept.
REQ-033 Mismatch: s1=8'h00, s2=8'h55 -> score=-4.
REQ-034 Shift: s1=8'h1B, s2=8'h6C (CGTA) -> score=1.
REQ-035 Backpressure: out_ready low 5 cycles -> out_valid and score stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-036 Reset: reset on the 2nd RUN cycle -> IDLE, out_valid=0, no score emitted; next job s1=s2=8'h1B -> score=4.
REQ-037 Back-to-back: in_valid held high over 3 jobs -> each accepted one cycle after the prior output handshake; all scores correct.

Source files
------------

// File: rtl/nw_pkg.sv
// nw_pkg: definitions shared by the Needleman-Wunsch blocks.
//   - FSM state encodings for the row scheduler
//   - default scoring weights
//   - nw_abs(): magnitude helper for signed weights
package nw_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NW_MATCH    = 1;
    localparam int NW_INDEL    = -1;
    localparam int NW_MISMATCH = -1;

    function automatic int nw_abs(input int v);
        return (v < 32'sd0) ? -v : v;
    endfunction

endpackage

// File: rtl/nw_cell.sv
// nw_cell: one Needleman-Wunsch DP cell (purely combinational).
//   top, left, diag : neighbouring scores (signed SWIDTH)
//   c1, c2          : the two characters compared at this cell
//   val             : max(top+INDEL, left+INDEL, diag+(c1==c2 ? MATCH : MISMATCH))
// All sums wrap in SWIDTH-bit two's complement.
module nw_cell
    import nw_pkg::*;
#(
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = NW_MATCH,
    parameter int INDEL    = NW_INDEL,
    parameter int MISMATCH = NW_MISMATCH
) (
    input  logic signed [SWIDTH-1:0] top,
    input  logic signed [SWIDTH-1:0] left,
    input  logic signed [SWIDTH-1:0] diag,
    input  logic        [CWIDTH-1:0] c1,
    input  logic        [CWIDTH-1:0] c2,
    output logic signed [SWIDTH-1:0] val
);

    localparam logic signed [SWIDTH-1:0] MATCH_W    = SWIDTH'(MATCH);
    localparam logic signed [SWIDTH-1:0] INDEL_W    = SWIDTH'(INDEL);
    localparam logic signed [SWIDTH-1:0] MISMATCH_W = SWIDTH'(MISMATCH);

    logic signed [SWIDTH-1:0] up_s;
    logic signed [SWIDTH-1:0] lf_s;
    logic signed [SWIDTH-1:0] dg_s;
    logic signed [SWIDTH-1:0] m1_s;

    // three candidate scores and their signed maximum
    always_comb begin
        up_s = top + INDEL_W;
        lf_s = left + INDEL_W;
        dg_s = diag + ((c1 == c2) ? MATCH_W : MISMATCH_W);
        m1_s = (lf_s > up_s) ? lf_s : up_s;
        val  = (dg_s > m1_s) ? dg_s : m1_s;
    end

endmodule

// File: rtl/nw_row_sched.sv
// nw_row_sched: Needleman-Wunsch global alignment score, one DP row per cycle.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, s1, s2 : job input handshake; strings packed char 1 in the MSBs
//   out_valid/out_ready, score : result handshake; score held while out_valid
//   busy                  : high while a job is running or waiting to be taken
// A job is accepted in IDLE, swept through LENGTH RUN cycles (row i = 1..LENGTH,
// each row a combinational chain of LENGTH nw_cell instances), then held in DONE.
module nw_row_sched
    import nw_pkg::*;
#(
    parameter int LENGTH   = 10,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = NW_MATCH,
    parameter int INDEL    = NW_INDEL,
    parameter int MISMATCH = NW_MISMATCH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SWIDTH-1:0]   score,
    output logic                       busy
);

    localparam int CNTW = $clog2(LENGTH + 1);
    localparam logic signed [SWIDTH-1:0] INDEL_W = SWIDTH'(INDEL);

    logic [1:0]                 state_q, state_d;
    logic [CNTW-1:0]            cnt_q, cnt_d;
    logic [LENGTH*CWIDTH-1:0]   s1_q, s1_d;
    logic [LENGTH*CWIDTH-1:0]   s2_q, s2_d;
    logic signed [SWIDTH-1:0]   r_q [LENGTH];
    logic signed [SWIDTH-1:0]   r_d [LENGTH];
    logic signed [SWIDTH-1:0]   new_row_s [LENGTH];
    logic signed [SWIDTH-1:0]   cnt_ext_s;
    logic signed [SWIDTH-1:0]   left0_s;
    logic signed [SWIDTH-1:0]   diag0_s;
    logic [CWIDTH-1:0]          c1_s;

    // column-0 boundary of the current row: left = i*INDEL, top-left = (i-1)*INDEL
    always_comb begin
        cnt_ext_s = SWIDTH'(cnt_q);
        left0_s   = cnt_ext_s * INDEL_W;
        diag0_s   = left0_s - INDEL_W;
    end

    // select character s1[i] for the row being computed (i is 1-based)
    always_comb begin
        c1_s = {CWIDTH{1'b0}};
        for (int k = 0; k < LENGTH; k++) begin
            c1_s = (cnt_q == CNTW'(k + 1)) ? s1_q[CWIDTH*(LENGTH-1-k) +: CWIDTH] : c1_s;
        end
    end

    // one cell per column; each cell's own output signal keeps the left-to-right chain acyclic
    for (genvar j = 0; j < LENGTH; j++) begin : g_cell
        logic signed [SWIDTH-1:0] left_s;
        logic signed [SWIDTH-1:0] diag_s;
        logic signed [SWIDTH-1:0] val_s;

        if (j == 0) begin : g_first
            assign left_s = left0_s;
            assign diag_s = diag0_s;
        end else begin : g_rest
            assign left_s = g_cell[j-1].val_s;
            assign diag_s = r_q[j-1];
        end

        nw_cell #(
            .CWIDTH   (CWIDTH),
            .SWIDTH   (SWIDTH),
            .MATCH    (MATCH),
            .INDEL    (INDEL),
            .MISMATCH (MISMATCH)
        ) u_cell (
            .top  (r_q[j]),
            .left (left_s),
            .diag (diag_s),
            .c1   (c1_s),
            .c2   (s2_q[CWIDTH*(LENGTH-1-j) +: CWIDTH]),
            .val  (val_s)
        );

        assign new_row_s[j] = val_s;
    end

    // FSM, row counter, string latch and row register next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    s1_d    = s1;
                    s2_d    = s2;
                    cnt_d   = CNTW'(1);
                    state_d = ST_RUN;
                    for (int j = 0; j < LENGTH; j++) begin
                        r_d[j] = SWIDTH'(-(j + 1) * nw_abs(INDEL));
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_d = new_row_s;
                if (cnt_q == CNTW'(LENGTH)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNTW{1'b0}};
            s1_q    <= {(LENGTH*CWIDTH){1'b0}};
            s2_q    <= {(LENGTH*CWIDTH){1'b0}};
            for (int j = 0; j < LENGTH; j++) begin
                r_q[j] <= {SWIDTH{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign score     = r_q[LENGTH-1];

endmodule

// File: tb/tb_nw_row_sched.sv
module tb_nw_row_sched;

    localparam int LENGTH = 4;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [LENGTH*CWIDTH-1:0] s1 = 8'h00;
    logic [LENGTH*CWIDTH-1:0] s2 = 8'h00;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [SWIDTH-1:0] score;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    nw_row_sched #(
        .LENGTH (LENGTH),
        .CWIDTH (CWIDTH),
        .SWIDTH (SWIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s1        (s1),
        .s2        (s2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .score     (score),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one full job with out_ready high; checks latency and score
    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int exp, input string nm);
        int cyc;
        @(negedge clock);
        check({nm, " in_ready"}, int'(in_ready), 1);
        s1 = a; s2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; s1 = ~a; s2 = ~b;
        check({nm, " busy"}, int'(busy), 1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        check({nm, " latency"}, cyc, LENGTH);
        check({nm, " score"}, int'(score), exp);
        @(posedge clock);
        @(negedge clock);
        check({nm, " out_valid drop"}, int'(out_valid), 0);
        check({nm, " back to idle"}, int'(in_ready), 1);
    endtask

    initial begin
        int cyc;
        int held;
        vecs[0] = '{8'h1B, 8'h1B, 4};   // ACGT / ACGT
        vecs[1] = '{8'h00, 8'h55, -4};  // AAAA / CCCC
        vecs[2] = '{8'h1B, 8'h6C, 1};   // ACGT / CGTA
        vecs[3] = '{8'h1B, 8'hE4, -3};  // ACGT / TGCA
        vecs[4] = '{8'h1B, 8'h1F, 2};   // ACGT / ACTT
        vecs[5] = '{8'hFF, 8'hFF, 4};   // TTTT / TTTT

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset in_ready", int'(in_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset score", int'(score), 0);

        // table-driven jobs
        for (int v = 0; v < 6; v++) begin
            do_job(vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // backpressure: out_ready low for 5 cycles in DONE, in_valid offered meanwhile
        @(negedge clock);
        s1 = 8'h1B; s2 = 8'h6C; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        s1 = 8'h00; s2 = 8'h55;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        check("bp latency", cyc, LENGTH);
        held = int'(score);
        check("bp score", held, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp out_valid held", int'(out_valid), 1);
            check("bp score held", int'(score), 1);
            check("bp in_ready low", int'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp release out_valid", int'(out_valid), 0);
        check("bp release in_ready", int'(in_ready), 1);
        check("bp release busy", int'(busy), 0);

        // reset on the second RUN cycle aborts the job
        s1 = 8'h00; s2 = 8'h00; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort in_ready", int'(in_ready), 1);
        check("abort busy", int'(busy), 0);
        check("abort out_valid", int'(out_valid), 0);
        check("abort score", int'(score), 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("abort no output", int'(out_valid), 0);
        end
        do_job(8'h1B, 8'h1B, 4, "after abort");

        // back-to-back: in_valid held high across three jobs
        @(negedge clock);
        out_ready = 1'b1;
        s1 = vecs[0].a; s2 = vecs[0].b; in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check("b2b in_ready", int'(in_ready), 1);
            @(posedge clock);
            @(negedge clock);
            check("b2b accepted", int'(busy), 1);
            s1 = vecs[j+1].a; s2 = vecs[j+1].b;
            if (j == 2) begin
                in_valid = 1'b0;
            end
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(posedge clock);
                @(negedge clock);
                cyc++;
            end
            check("b2b latency", cyc, LENGTH);
            check("b2b score", int'(score), vecs[j].exp);
            @(posedge clock);
            @(negedge clock);
            check("b2b idle gap", int'(out_valid), 0);
        end
        check("b2b final idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
